// File: rtl/la_pkg.sv
// la_pkg: shared logic-analyser constants and readout state encoding
package la_pkg;
  localparam int RAM_SIZE = 1536;
  localparam int ADDR_W = 11;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_LOAD, S_SEND, S_CSUM, S_FIN} state_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: loadable up-counter that wraps from MAX-1 back to 0
module wrap_counter #(
  parameter int MAX = 1536,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  // load has priority over increment; the last location rolls over to 0
  always_comb q_d = ld_i ? ld_val_i : inc_i ? ((q_q == W'(MAX - 1)) ? '0 : q_q + 1'b1) : q_q;
  // counter register, cleared by the active-low asynchronous reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/readout.sv
// readout: streams the sample RAM to the host link oldest-first, one transfer per grant; READOUT_CHECKSUM_EN appends an XOR checksum byte
module readout #(
  parameter int RAM_SIZE = la_pkg::RAM_SIZE,
  parameter int ADDR_W = la_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_rd,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              done_rd,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  import la_pkg::*;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(RAM_SIZE - 1);
  state_t          state_q;
  logic            armed_q, rd_en_q, tx_valid_q, done_q;
  logic [7:0]      tx_data_q;
  logic [ADDR_W:0] cnt_q;
  logic            addr_ld, addr_inc;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif
  assign addr_ld  = (state_q == S_IDLE) & grant_rd & armed_q;
  assign addr_inc = (state_q == S_SEND) & tx_ready;
  wrap_counter #(.MAX(RAM_SIZE), .W(ADDR_W)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (addr_ld),
    .ld_val_i (start_addr),
    .inc_i    (addr_inc),
    .q_o      (rd_addr)
  );
  // transfer sequencer: READ -> LOAD -> SEND per byte; losing the grant anywhere aborts to IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
`ifdef READOUT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else if (state_q != S_IDLE && !grant_rd) begin
      state_q    <= S_IDLE;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:
          if (!grant_rd) armed_q <= 1'b1;
          else if (armed_q) begin
            state_q <= S_READ;
            rd_en_q <= 1'b1;
            cnt_q   <= '0;
`ifdef READOUT_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        S_READ: begin
          state_q <= S_LOAD;
          rd_en_q <= 1'b0;
        end
        S_LOAD: begin
          state_q    <= S_SEND;
          tx_data_q  <= rd_data;
          tx_valid_q <= 1'b1;
        end
        S_SEND:
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 1'b1;
`ifdef READOUT_CHECKSUM_EN
            csum_q     <= csum_q ^ tx_data_q;
`endif
            if (cnt_q == LAST) begin
`ifdef READOUT_CHECKSUM_EN
              state_q    <= S_CSUM;
              tx_data_q  <= csum_q ^ tx_data_q;
              tx_valid_q <= 1'b1;
`else
              state_q <= S_FIN;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= S_READ;
              rd_en_q <= 1'b1;
            end
          end
`ifdef READOUT_CHECKSUM_EN
        S_CSUM:
          if (tx_ready) begin
            state_q    <= S_FIN;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b1;
          end
`endif
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          armed_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  assign done_rd  = done_q;
  assign rd_en    = rd_en_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
endmodule
